// File: rtl/pll_rst_sequencer.sv
// -----------------------------------------------------------------------------
// pll_rst_sequencer
//
// Power-up / recovery sequencer for the board PLL, clocked by the free-running
// reference clock. It pulses the PLL reset and waits for lock, giving up after
// a timeout with bounded retries. Lock must then hold steady for a qualification
// window before the downstream system reset is released. Losing lock while
// running restarts the whole sequence.
//
// Ports:
//   clk           in   reference clock, free-running
//   rst_n         in   asynchronous active-low reset
//   soft_rst_req  in   single-cycle request to restart sequencing
//   pll_lock_in   in   PLL lock indicator, asynchronous to clk
//   pll_rst       out  PLL reset, active-high (RESET or FAIL)
//   sys_rst_n     out  downstream system reset, active-low (low unless RUN)
//   locked        out  qualified lock status (RUN)
//   fail          out  retries exhausted (FAIL)
//   retry_cnt     out  lock timeouts since the last RUN or soft reset
//   state         out  FSM state: RESET=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAIL=4
// -----------------------------------------------------------------------------
module pll_rst_sequencer #(
  parameter int RST_PULSE_CYCLES    = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRY           = 7,
  parameter int CNT_W               = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       pll_lock_in,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_e;

  // Terminal counts: each phase lasts exactly N cycles, counting from 0.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRY);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_retry_cnt;
  logic             r_lock_meta;
  logic             r_lock_s;

  state_e           w_state_nxt;
  logic [2:0]       w_retry_nxt;
  logic             w_cnt_clr;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous lock input. Only r_lock_s may
  // feed the FSM; r_lock_meta can be metastable.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the values
  // from before the edge; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock_in;
      r_lock_s    <= r_lock_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and retry logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here is given a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_cnt;

    if (soft_rst_req) begin
      // Outranks every other condition, including a restart while in RESET.
      w_state_nxt = ST_RESET;
      w_retry_nxt = 3'd0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (r_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            if (r_retry_cnt == RETRY_MAX) begin
              w_state_nxt = ST_FAIL;
            end else begin
              w_state_nxt = ST_RESET;
              w_retry_nxt = r_retry_cnt + 3'd1;
            end
          end
        end
        ST_STABLE: begin
          // A lock drop wins over a coincident end of the stability window.
          if (!r_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt = ST_RUN;
            w_retry_nxt = 3'd0;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) w_state_nxt = ST_RESET;
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          // Illegal encodings recover through a full reset pulse.
          w_state_nxt = ST_RESET;
        end
      endcase
    end
  end

  // The counter restarts on any state change and on a soft reset, even when
  // the soft reset leaves the FSM in RESET. In RUN and FAIL it free-runs and
  // may wrap; its value is ignored there.
  assign w_cnt_clr = soft_rst_req || (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_retry_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      r_retry_cnt <= w_retry_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs, decoded directly from the state register.
  // ---------------------------------------------------------------------------
  assign pll_rst   = (r_state == ST_RESET) || (r_state == ST_FAIL);
  assign sys_rst_n = (r_state == ST_RUN);
  assign locked    = (r_state == ST_RUN);
  assign fail      = (r_state == ST_FAIL);
  assign retry_cnt = r_retry_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_rst_sequencer
//
// Directed bench for pll_rst_sequencer with short parameters
// (pulse 4, timeout 32, stable 8, max retry 2). Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pll_rst_sequencer;

  logic       clk;
  logic       rst_n;
  logic       soft_rst_req;
  logic       pll_lock_in;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       locked;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [2:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  pll_rst_sequencer #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .MAX_RETRY          (2),
    .CNT_W              (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst_req(soft_rst_req),
    .pll_lock_in (pll_lock_in),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .locked      (locked),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- stimulus / measurement helpers (no checking inside) -----------------

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts consecutive falling edges (starting with the current one) on which
  // pll_rst is high; returns on the first edge where it is low.
  task automatic pll_rst_len(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Same, for the number of cycles spent in state s.
  task automatic state_len(input logic [2:0] s, output int n);
    n = 0;
    while (state === s && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Advances until state == s, at most budget cycles.
  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (k < budget) begin
      if (state === s) begin
        ok = 1'b1;
        break;
      end
      k++;
      @(negedge clk);
    end
  endtask

  // ---- scenarios ------------------------------------------------------------

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL rst_state: got %0d want 0", state); end
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
    tests_run++; if (sys_rst_n !== 1'b0) begin tests_failed++; $display("FAIL rst_sys_rst_n: got %b want 0", sys_rst_n); end
    tests_run++; if (locked !== 1'b0) begin tests_failed++; $display("FAIL rst_locked: got %b want 0", locked); end
    tests_run++; if (fail !== 1'b0) begin tests_failed++; $display("FAIL rst_fail: got %b want 0", fail); end
    tests_run++; if (retry_cnt !== 3'd0) begin tests_failed++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_normal_start();
    int n;
    int k;
    rst_n = 1'b1;
    pll_rst_len(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL normal_pulse_len: got %0d want 4", n); end
    repeat (10) @(negedge clk);
    pll_lock_in = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sys_rst_n !== 1'b1 && k < 100);
    tests_run++; if (k != 11) begin tests_failed++; $display("FAIL normal_lock_latency: got %0d want 11", k); end
    tests_run++; if (locked !== 1'b1) begin tests_failed++; $display("FAIL normal_locked: got %b want 1", locked); end
    tests_run++; if (retry_cnt !== 3'd0) begin tests_failed++; $display("FAIL normal_retry: got %0d want 0", retry_cnt); end
    tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL normal_state: got %0d want 3", state); end
  endtask

  task automatic test_lock_glitch();
    int n;
    bit ok;
    pll_lock_in = 1'b0;
    apply_reset();
    wait_state(3'd1, 20, ok);
    state_len(3'd1, n);
    tests_run++; if (n != 32) begin tests_failed++; $display("FAIL glitch_timeout_len: got %0d want 32", n); end
    wait_state(3'd1, 20, ok);
    pll_lock_in = 1'b1;
    wait_state(3'd2, 20, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL glitch_reach_stable: got state %0d want 2", state); end
    repeat (5) @(negedge clk);
    tests_run++; if (retry_cnt !== 3'd1) begin tests_failed++; $display("FAIL glitch_retry_stable: got %0d want 1", retry_cnt); end
    pll_lock_in = 1'b0;
    repeat (2) @(negedge clk);
    // The synchronized drop lands on the same edge as the end of the window.
    tests_run++; if (state !== 3'd2) begin tests_failed++; $display("FAIL glitch_still_stable: got %0d want 2", state); end
    @(negedge clk);
    tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL glitch_back_to_wait: got %0d want 1", state); end
    tests_run++; if (sys_rst_n !== 1'b0) begin tests_failed++; $display("FAIL glitch_sys_rst_n: got %b want 0", sys_rst_n); end
    tests_run++; if (retry_cnt !== 3'd1) begin tests_failed++; $display("FAIL glitch_retry_kept: got %0d want 1", retry_cnt); end
    pll_lock_in = 1'b1;
    wait_state(3'd2, 20, ok);
    state_len(3'd2, n);
    tests_run++; if (n != 8) begin tests_failed++; $display("FAIL glitch_relock_len: got %0d want 8", n); end
    tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL glitch_run_state: got %0d want 3", state); end
    tests_run++; if (retry_cnt !== 3'd0) begin tests_failed++; $display("FAIL glitch_run_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_lock_loss();
    int n;
    bit ok;
    pll_lock_in = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (sys_rst_n !== 1'b1) begin tests_failed++; $display("FAIL loss_sys_early: got %b want 1", sys_rst_n); end
    @(negedge clk);
    tests_run++; if (sys_rst_n !== 1'b0) begin tests_failed++; $display("FAIL loss_sys_drop: got %b want 0", sys_rst_n); end
    pll_rst_len(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL loss_pulse_len: got %0d want 4", n); end
    pll_lock_in = 1'b1;
    wait_state(3'd3, 40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL loss_relock: got state %0d want 3", state); end
    tests_run++; if (retry_cnt !== 3'd0) begin tests_failed++; $display("FAIL loss_retry: got %0d want 0", retry_cnt); end
  endtask

  task automatic test_never_lock();
    int n;
    pll_lock_in = 1'b0;
    apply_reset();
    for (int a = 0; a < 3; a++) begin
      pll_rst_len(n);
      tests_run++; if (n != 4) begin tests_failed++; $display("FAIL never_pulse_len[%0d]: got %0d want 4", a, n); end
      tests_run++; if (retry_cnt !== 3'(a)) begin tests_failed++; $display("FAIL never_retry[%0d]: got %0d want %0d", a, retry_cnt, a); end
      state_len(3'd1, n);
      tests_run++; if (n != 32) begin tests_failed++; $display("FAIL never_wait_len[%0d]: got %0d want 32", a, n); end
    end
    repeat (5) @(negedge clk);
    tests_run++; if (state !== 3'd4) begin tests_failed++; $display("FAIL never_state: got %0d want 4", state); end
    tests_run++; if (fail !== 1'b1) begin tests_failed++; $display("FAIL never_fail: got %b want 1", fail); end
    tests_run++; if (pll_rst !== 1'b1) begin tests_failed++; $display("FAIL never_pll_rst: got %b want 1", pll_rst); end
    tests_run++; if (sys_rst_n !== 1'b0) begin tests_failed++; $display("FAIL never_sys_rst_n: got %b want 0", sys_rst_n); end
    tests_run++; if (retry_cnt !== 3'd2) begin tests_failed++; $display("FAIL never_retry_sat: got %0d want 2", retry_cnt); end
  endtask

  task automatic test_soft_reset();
    int n;
    // From FAIL.
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL soft_fail_state: got %0d want 0", state); end
    tests_run++; if (retry_cnt !== 3'd0) begin tests_failed++; $display("FAIL soft_fail_retry: got %0d want 0", retry_cnt); end
    tests_run++; if (fail !== 1'b0) begin tests_failed++; $display("FAIL soft_fail_flag: got %b want 0", fail); end
    pll_rst_len(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL soft_fail_pulse: got %0d want 4", n); end
    // Let one timeout happen so retry_cnt is non-zero.
    state_len(3'd1, n);
    tests_run++; if (retry_cnt !== 3'd1) begin tests_failed++; $display("FAIL soft_pre_retry: got %0d want 1", retry_cnt); end
    pll_rst_len(n);
    // Soft request on the same cycle as the second timeout.
    repeat (31) @(negedge clk);
    tests_run++; if (state !== 3'd1) begin tests_failed++; $display("FAIL soft_pre_wait: got %0d want 1", state); end
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL soft_timeout_state: got %0d want 0", state); end
    tests_run++; if (retry_cnt !== 3'd0) begin tests_failed++; $display("FAIL soft_timeout_retry: got %0d want 0", retry_cnt); end
    // Soft request part-way through a pulse restarts it at full length.
    repeat (2) @(negedge clk);
    soft_rst_req = 1'b1;
    @(negedge clk);
    soft_rst_req = 1'b0;
    pll_rst_len(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL soft_restart_pulse: got %0d want 4", n); end
  endtask

  task automatic test_async_reset();
    int n;
    bit ok;
    pll_lock_in = 1'b1;
    apply_reset();
    wait_state(3'd2, 40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL async_reach_stable: got state %0d want 2", state); end
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++; if (state !== 3'd0) begin tests_failed++; $display("FAIL async_state: got %0d want 0", state); end
    tests_run++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 || fail !== 1'b0 || retry_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL async_outputs: got pll_rst=%b sys_rst_n=%b locked=%b fail=%b retry=%0d want 1 0 0 0 0",
               pll_rst, sys_rst_n, locked, fail, retry_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pll_rst_len(n);
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL async_pulse_len: got %0d want 4", n); end
    state_len(3'd1, n);
    tests_run++; if (n != 1) begin tests_failed++; $display("FAIL async_wait_len: got %0d want 1", n); end
    state_len(3'd2, n);
    tests_run++; if (n != 8) begin tests_failed++; $display("FAIL async_stable_len: got %0d want 8", n); end
    tests_run++; if (state !== 3'd3) begin tests_failed++; $display("FAIL async_run: got %0d want 3", state); end
  endtask

  initial begin
    rst_n        = 1'b0;
    soft_rst_req = 1'b0;
    pll_lock_in  = 1'b0;
    test_reset();
    test_normal_start();
    test_lock_glitch();
    test_lock_loss();
    test_never_lock();
    test_soft_reset();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
